// File: rtl/bpu_pkg.sv
// bpu_pkg: control-flow opcodes, funct3 codes and PHT counter states shared by the branch predictor
package bpu_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    localparam logic [2:0] F3_JALR = 3'b000;

    localparam logic [1:0] SNT = 2'd0;
    localparam logic [1:0] WNT = 2'd1;
    localparam logic [1:0] WT  = 2'd2;
    localparam logic [1:0] ST  = 2'd3;

    // x1 (ra) and x5 (t0) are the link registers for call/return hinting
    function automatic logic is_link(input logic [4:0] r);
        return r == 5'd1 || r == 5'd5;
    endfunction

endpackage

// File: rtl/bpu_ras.sv
// bpu_ras: circular return address stack; overflow overwrites the oldest entry, underflow is ignored
module bpu_ras #(
    parameter int RAS_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic [31:0] data_i,
    output logic [31:0] top_o,
    output logic        empty_o
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

    logic [31:0]   stack_q [RAS_DEPTH];
    logic [PW-1:0] ptr_q, ptr_d, top_idx;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_pop;

    assign top_idx = ptr_q - PW'(1);
    assign empty_o = cnt_q == '0;
    assign top_o   = stack_q[top_idx];
    assign do_pop  = pop_i && !empty_o;

    // pop+push replaces the top in place, so pointer and count only move on a lone push or pop
    always_comb begin
        ptr_d = do_pop && !push_i ? top_idx : push_i && !do_pop ? ptr_q + PW'(1) : ptr_q;
        cnt_d = do_pop && !push_i ? cnt_q - CW'(1) :
                push_i && !do_pop && cnt_q != FULL ? cnt_q + CW'(1) : cnt_q;
    end

    // pointer and occupancy registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // return address storage; contents are meaningless while the count says empty
    always_ff @(posedge clock) begin
        if (push_i) stack_q[do_pop ? top_idx : ptr_q] <= data_i;
    end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: same-cycle direction/target prediction from a PHT, a tagged BTB and a RAS
module branch_predictor
    import bpu_pkg::*;
#(
    parameter int PHT_DEPTH  = 64,
    parameter int BTB_DEPTH  = 16,
    parameter int RAS_DEPTH  = 4,
    parameter int GHR_WIDTH  = 6,
    parameter int USE_GSHARE = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fetch_valid_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] inst_i,
    output logic        is_branch_o,
    output logic        taken_o,
    output logic [31:0] dnpc_o,
    input  logic        upd_valid_i,
    input  logic [31:0] upd_pc_i,
    input  logic        upd_is_cond_i,
    input  logic        upd_is_jalr_i,
    input  logic        upd_taken_i,
    input  logic [31:0] upd_target_i
);

    localparam int PI = $clog2(PHT_DEPTH);
    localparam int BI = $clog2(BTB_DEPTH);
    localparam int TW = 30 - BI;

    logic [1:0]           pht_q [PHT_DEPTH];
    logic [1:0]           pht_d;
    logic [GHR_WIDTH-1:0] ghr_q;
    logic                 btb_valid_q [BTB_DEPTH];
    logic [TW-1:0]        btb_tag_q [BTB_DEPTH];
    logic [31:0]          btb_tgt_q [BTB_DEPTH];

    logic [6:0]    opcode;
    logic [2:0]    funct3;
    logic [4:0]    rd, rs1;
    logic [31:0]   imm_b, imm_j, ras_top;
    logic [PI-1:0] hist, pidx, uidx;
    logic [BI-1:0] bidx, ubidx;
    logic          is_cond, is_jal, is_jalr, is_ret, use_ras, btb_hit, pred_t, ras_empty;

    assign opcode = inst_i[6:0];
    assign funct3 = inst_i[14:12];
    assign rd     = inst_i[11:7];
    assign rs1    = inst_i[19:15];
    assign imm_b  = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    assign imm_j  = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

    assign is_cond = opcode == OP_BRANCH &&
                     (funct3 inside {F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU});
    assign is_jal  = opcode == OP_JAL;
    assign is_jalr = opcode == OP_JALR && funct3 == F3_JALR;
    assign is_ret  = is_jalr && rd == 5'd0 && is_link(rs1);
    assign use_ras = is_ret && !ras_empty;

    // prediction and training share the same history so a resolved branch trains the slot it read
    assign hist    = USE_GSHARE != 0 ? PI'(ghr_q) : '0;
    assign pidx    = pc_i[PI+1:2] ^ hist;
    assign uidx    = upd_pc_i[PI+1:2] ^ hist;
    assign pred_t  = pht_q[pidx][1];
    assign bidx    = pc_i[BI+1:2];
    assign ubidx   = upd_pc_i[BI+1:2];
    assign btb_hit = btb_valid_q[bidx] && btb_tag_q[bidx] == pc_i[31:BI+2];

    assign is_branch_o = is_cond || is_jal || is_jalr;
    assign taken_o     = is_cond ? pred_t : is_jal || use_ras || (is_jalr && btb_hit);
    assign dnpc_o      = is_cond && pred_t    ? pc_i + imm_b :
                         is_jal               ? pc_i + imm_j :
                         use_ras              ? ras_top :
                         is_jalr && btb_hit   ? btb_tgt_q[bidx] : pc_i + 32'd4;

    assign pht_d = upd_taken_i ? (pht_q[uidx] == ST ? ST : pht_q[uidx] + 2'd1)
                               : (pht_q[uidx] == SNT ? SNT : pht_q[uidx] - 2'd1);

    bpu_ras #(.RAS_DEPTH(RAS_DEPTH)) u_ras (
        .clock   (clock),
        .reset   (reset),
        .push_i  (fetch_valid_i && (is_jal || is_jalr) && is_link(rd)),
        .pop_i   (fetch_valid_i && is_ret),
        .data_i  (pc_i + 32'd4),
        .top_o   (ras_top),
        .empty_o (ras_empty)
    );

    // saturating counter training and global history shift on resolved conditional branches
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < PHT_DEPTH; i++) pht_q[i] <= WNT;
            ghr_q <= '0;
        end else if (upd_valid_i && upd_is_cond_i) begin
            pht_q[uidx] <= pht_d;
            ghr_q       <= {ghr_q[GHR_WIDTH-2:0], upd_taken_i};
        end
    end

    // BTB valid bits, cleared on reset and set by taken indirect jumps
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BTB_DEPTH; i++) btb_valid_q[i] <= 1'b0;
        end else if (upd_valid_i && upd_is_jalr_i && upd_taken_i) begin
            btb_valid_q[ubidx] <= 1'b1;
        end
    end

    // BTB tag and target payload, qualified by the valid bit
    always_ff @(posedge clock) begin
        if (upd_valid_i && upd_is_jalr_i && upd_taken_i) begin
            btb_tag_q[ubidx] <= upd_pc_i[31:BI+2];
            btb_tgt_q[ubidx] <= upd_target_i;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed and random checks of the predictor against a behavioural model
module tb_branch_predictor;

    localparam int PHT = 64;
    localparam int BTB = 16;
    localparam int RAS = 4;
    localparam int GHW = 6;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        fv = 1'b0, uv = 1'b0, ucond = 1'b0, ujalr = 1'b0, utaken = 1'b0;
    logic [31:0] pc = '0, inst = '0, upc = '0, utgt = '0;
    logic        b0, t0, b1, t1;
    logic [31:0] d0, d1;

    int npass = 0;
    int ntot  = 0;
    bit go    = 1'b0;

    int          pht [2][PHT];
    int          ghr;
    bit          bv [BTB];
    logic [31:0] btag [BTB];
    logic [31:0] btgt [BTB];
    logic [31:0] ras [$];

    always #5 clock = ~clock;

    branch_predictor #(.PHT_DEPTH(PHT), .BTB_DEPTH(BTB), .RAS_DEPTH(RAS), .GHR_WIDTH(GHW), .USE_GSHARE(0)) u0 (
        .clock(clock), .reset(reset), .fetch_valid_i(fv), .pc_i(pc), .inst_i(inst),
        .is_branch_o(b0), .taken_o(t0), .dnpc_o(d0),
        .upd_valid_i(uv), .upd_pc_i(upc), .upd_is_cond_i(ucond), .upd_is_jalr_i(ujalr),
        .upd_taken_i(utaken), .upd_target_i(utgt)
    );

    branch_predictor #(.PHT_DEPTH(PHT), .BTB_DEPTH(BTB), .RAS_DEPTH(RAS), .GHR_WIDTH(GHW), .USE_GSHARE(1)) u1 (
        .clock(clock), .reset(reset), .fetch_valid_i(fv), .pc_i(pc), .inst_i(inst),
        .is_branch_o(b1), .taken_o(t1), .dnpc_o(d1),
        .upd_valid_i(uv), .upd_pc_i(upc), .upd_is_cond_i(ucond), .upd_is_jalr_i(ujalr),
        .upd_taken_i(utaken), .upd_target_i(utgt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic lit(input string name, input bit eb, input bit et, input logic [31:0] ed);
        chk(name, {30'd0, b0, t0, d0}, {30'd0, eb, et, ed});
    endtask

    function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [12:0] im);
        return {im[12], im[10:5], 5'd2, 5'd1, f3, im[4:1], im[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_jal(input logic [4:0] rd, input logic [20:0] im);
        return {im[20], im[10:1], im[11], im[19:12], rd, 7'h6f};
    endfunction

    function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs);
        return {12'd0, rs, 3'd0, rd, 7'h67};
    endfunction

    function automatic bit lnk(input logic [4:0] r);
        return r == 5'd1 || r == 5'd5;
    endfunction

    // expected {is_branch, taken, dnpc} for history mode g (0 = bimodal, 1 = gshare)
    function automatic logic [33:0] mpred(input int g, input logic [31:0] p, input logic [31:0] i);
        int idx, bi;
        logic [31:0] ib, ij;
        ib = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
        ij = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
        if (i[6:0] == 7'h63 && i[14:12] != 3'd2 && i[14:12] != 3'd3) begin
            idx = int'((p >> 2) % PHT) ^ (g != 0 ? ghr : 0);
            return pht[g][idx] >= 2 ? {2'b11, p + ib} : {2'b10, p + 32'd4};
        end
        if (i[6:0] == 7'h6f) return {2'b11, p + ij};
        if (i[6:0] == 7'h67 && i[14:12] == 3'd0) begin
            if (i[11:7] == 5'd0 && lnk(i[19:15]) && ras.size() > 0) return {2'b11, ras[ras.size()-1]};
            bi = int'((p >> 2) % BTB);
            if (bv[bi] && btag[bi] == (p >> 6)) return {2'b11, btgt[bi]};
            return {2'b10, p + 32'd4};
        end
        return {2'b00, p + 32'd4};
    endfunction

    task automatic mreset();
        for (int g = 0; g < 2; g++) for (int k = 0; k < PHT; k++) pht[g][k] = 1;
        for (int k = 0; k < BTB; k++) bv[k] = 1'b0;
        ghr = 0;
        ras.delete();
    endtask

    task automatic mstep();
        bit isj, psh, pop, rep;
        int idx, b;
        isj = inst[6:0] == 7'h6f || (inst[6:0] == 7'h67 && inst[14:12] == 3'd0);
        psh = fv && isj && lnk(inst[11:7]);
        pop = fv && inst[6:0] == 7'h67 && inst[14:12] == 3'd0 && inst[11:7] == 5'd0 && lnk(inst[19:15]);
        rep = 1'b0;
        if (pop && ras.size() > 0) begin
            if (psh) begin
                ras[ras.size()-1] = pc + 32'd4;
                rep = 1'b1;
            end else void'(ras.pop_back());
        end
        if (psh && !rep) begin
            ras.push_back(pc + 32'd4);
            if (ras.size() > RAS) void'(ras.pop_front());
        end
        if (uv && ucond) begin
            for (int g = 0; g < 2; g++) begin
                idx = int'((upc >> 2) % PHT) ^ (g != 0 ? ghr : 0);
                pht[g][idx] = utaken ? (pht[g][idx] == 3 ? 3 : pht[g][idx] + 1)
                                     : (pht[g][idx] == 0 ? 0 : pht[g][idx] - 1);
            end
            ghr = ((ghr << 1) | int'(utaken)) % (1 << GHW);
        end
        if (uv && ujalr && utaken) begin
            b = int'((upc >> 2) % BTB);
            bv[b]   = 1'b1;
            btag[b] = upc >> 6;
            btgt[b] = utgt;
        end
    endtask

    always @(posedge clock or negedge reset) begin
        if (!reset) mreset();
        else mstep();
    end

    always @(negedge clock) begin
        if (go) begin
            chk("pred_bimodal", {30'd0, b0, t0, d0}, {30'd0, mpred(0, pc, inst)});
            chk("pred_gshare",  {30'd0, b1, t1, d1}, {30'd0, mpred(1, pc, inst)});
        end
    end

    always @(posedge clock) begin
        assert (!(uv && ucond && ujalr)) else $error("illegal update: cond and jalr together");
    end

    task automatic drv(input bit f, input logic [31:0] p, input logic [31:0] i,
                       input bit v = 1'b0, input logic [31:0] up = '0, input bit c = 1'b0,
                       input bit j = 1'b0, input bit t = 1'b0, input logic [31:0] tg = '0);
        @(posedge clock);
        #1;
        fv = f; pc = p; inst = i; uv = v; upc = up; ucond = c; ujalr = j; utaken = t; utgt = tg;
        #1;
    endtask

    logic [2:0] f3s [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [4:0] regs [4] = '{5'd0, 5'd1, 5'd5, 5'd6};

    initial begin
        logic [31:0] beq16, s, rp, ri, rt, ru;
        int k, m;
        mreset();
        #1 reset = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        go = 1'b1;
        beq16 = enc_b(3'd0, 13'd16);

        drv(1, 32'h8000_0010, beq16);
        lit("beq_reset", 1, 0, 32'h8000_0014);
        repeat (2) drv(1, 32'h8000_0010, beq16, 1, 32'h8000_0010, 1, 0, 1);
        drv(1, 32'h8000_0010, beq16);
        lit("beq_trained", 1, 1, 32'h8000_0020);

        s = 32'h8000_0040;
        repeat (5) drv(1, s, beq16, 1, s, 1, 0, 1);
        drv(1, s, beq16, 1, s, 1, 0, 0);
        lit("sat_st", 1, 1, s + 32'd16);
        drv(1, s, beq16);
        lit("sat_wt", 1, 1, s + 32'd16);
        repeat (3) drv(1, s, beq16, 1, s, 1, 0, 0);
        drv(1, s, beq16);
        lit("sat_snt", 1, 0, s + 32'd4);

        drv(1, 32'h8000_0100, enc_jal(5'd1, 21'h100));
        lit("jal", 1, 1, 32'h8000_0200);
        drv(1, 32'h8000_0300, enc_jalr(5'd0, 5'd1));
        lit("ret_hit", 1, 1, 32'h8000_0104);
        drv(1, 32'h8000_0300, enc_jalr(5'd0, 5'd1));
        lit("ret_empty", 1, 0, 32'h8000_0304);

        for (int n = 0; n < 5; n++) drv(1, 32'h8000_1000 + 32'(16 * n), enc_jal(5'd5, 21'h40));
        for (int n = 0; n < 4; n++) begin
            drv(1, 32'h8000_2000, enc_jalr(5'd0, 5'd5));
            lit($sformatf("ras_pop%0d", n), 1, 1, 32'h8000_1004 + 32'(16 * (4 - n)));
        end
        drv(1, 32'h8000_2000, enc_jalr(5'd0, 5'd5));
        lit("ras_under", 1, 0, 32'h8000_2004);

        drv(1, 32'h8000_0200, enc_jalr(5'd0, 5'd6), 1, 32'h8000_0200, 0, 1, 1, 32'h8000_1000);
        lit("btb_miss", 1, 0, 32'h8000_0204);
        drv(1, 32'h8000_0200, enc_jalr(5'd0, 5'd6));
        lit("btb_hit", 1, 1, 32'h8000_1000);
        drv(1, 32'h8000_0600, enc_jalr(5'd0, 5'd6));
        lit("btb_alias", 1, 0, 32'h8000_0604);

        drv(1, 32'h8000_0010, beq16);
        lit("pre_rst", 1, 1, 32'h8000_0020);
        reset = 1'b0;
        #1 lit("rst_beq", 1, 0, 32'h8000_0014);
        pc = 32'h8000_0200; inst = enc_jalr(5'd0, 5'd6);
        #1 lit("rst_btb", 1, 0, 32'h8000_0204);
        pc = 32'h8000_0100; inst = enc_jal(5'd1, 21'h100);
        #1 lit("rst_jal", 1, 1, 32'h8000_0200);
        reset = 1'b1;

        repeat (3000) begin
            rp = 32'h8000_0000 | 32'($urandom_range(0, 63) << 2) | 32'($urandom_range(0, 1) << 12);
            ru = 32'h8000_0000 | 32'($urandom_range(0, 63) << 2) | 32'($urandom_range(0, 1) << 12);
            k  = $urandom_range(0, 9);
            m  = $urandom_range(0, 2);
            ri = k < 4 ? enc_b(f3s[$urandom_range(0, 5)], 13'($urandom)) :
                 k < 6 ? enc_jal(regs[$urandom_range(0, 3)], 21'($urandom)) :
                 k < 9 ? enc_jalr(regs[$urandom_range(0, 3)], regs[$urandom_range(0, 3)]) : $urandom;
            rt = $urandom & 32'hffff_fffc;
            drv(1'($urandom_range(0, 1)), rp, ri, 1'($urandom_range(0, 1)), ru, m == 0, m == 1,
                1'($urandom_range(0, 1)), rt);
        end

        @(posedge clock);
        #1;
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
